// File: rtl/sr_arb_pkg.sv
// Shared types and constants for the SR flag arbiter: FSM state encoding,
// operation codes and the width of the optional conflict counter.
package sr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      CLRALL = 2'd2
   } arb_state_t;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

   localparam int CONFLICT_CNT_W = 16;

endpackage

// File: rtl/sr_cell.sv
// One SR flag cell: holds when idle, clear dominates set, synchronous reset to 0.
module sr_cell (
   input  logic clk,
   input  logic reset,
   input  logic set,
   input  logic clr,
   output logic q,
   output logic qbar
);

   always_ff @(posedge clk) begin
      if (reset)    q <= 1'b0;
      else if (clr) q <= 1'b0;
      else if (set) q <= 1'b1;
   end

   assign qbar = ~q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting NREQ requesters set/clear access to NFLAGS SR cells.
// Optional saturating conflict counter enabled by SR_FLAG_ARBITER_CONFLICT_CNT_EN.
//
//   state  | meaning
//   IDLE   | sample clr_all / req, pick winner, latch its op and idx
//   APPLY  | pulse gnt for the winner, update its cell, advance ptr
//   CLRALL | clear every cell, no grant
module sr_flag_arbiter
   import sr_arb_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int NFLAGS = 8,
   localparam int IDXW  = $clog2(NFLAGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          op,
   input  logic [NREQ*IDXW-1:0]     idx,
   input  logic                     clr_all,
   output logic [NREQ-1:0]          gnt,
   output logic [NFLAGS-1:0]        q,
   output logic [NFLAGS-1:0]        qbar,
`ifdef SR_FLAG_ARBITER_CONFLICT_CNT_EN
   output logic [CONFLICT_CNT_W-1:0] conflict_cnt,
`endif
   output logic                     busy
);

   localparam int PTRW = $clog2(NREQ);

   arb_state_t       state, state_nxt;
   logic [PTRW-1:0]  ptr, win_l, win_c, cand;
   logic             found, op_l, op_c;
   logic [IDXW-1:0]  idx_l, idx_c;
   logic             apply_en, clear_en, arb_en;
   logic [NFLAGS-1:0] cell_set, cell_clr;

   // Search starts just after the last granted requester.
   always_comb begin
      found = 1'b0;
      win_c = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = PTRW'((int'(ptr) + k) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win_c = cand;
         end
      end
      op_c  = 1'b0;
      idx_c = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_c == PTRW'(i)) begin
            op_c  = op[i];
            idx_c = idx[i*IDXW +: IDXW];
         end
      end
   end

   assign arb_en = (state == IDLE) && !clr_all && found;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (clr_all)    state_nxt = CLRALL;
            else if (found) state_nxt = APPLY;
         end
         APPLY:   state_nxt = IDLE;
         CLRALL:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr   <= PTRW'(NREQ - 1);
         win_l <= '0;
         op_l  <= 1'b0;
         idx_l <= '0;
      end else begin
         if (arb_en) begin
            win_l <= win_c;
            op_l  <= op_c;
            idx_l <= idx_c;
         end
         if (state == APPLY) ptr <= win_l;
      end
   end

   // Reset in the same cycle as APPLY/CLRALL suppresses the grant.
   assign apply_en = (state == APPLY) && !reset;
   assign clear_en = (state == CLRALL) && !reset;
   assign busy     = (state != IDLE);

   always_comb begin
      gnt = '0;
      if (apply_en) gnt[win_l] = 1'b1;
   end

   for (genvar j = 0; j < NFLAGS; j++) begin : g_cell
      assign cell_set[j] = apply_en && (op_l == OP_SET) && (idx_l == IDXW'(j));
      assign cell_clr[j] = clear_en || (apply_en && (op_l == OP_CLR) && (idx_l == IDXW'(j)));
      sr_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .set   (cell_set[j]),
         .clr   (cell_clr[j]),
         .q     (q[j]),
         .qbar  (qbar[j])
      );
   end

`ifdef SR_FLAG_ARBITER_CONFLICT_CNT_EN
   logic [CONFLICT_CNT_W-1:0] conflict_cnt_r;

   always_ff @(posedge clk) begin
      if (reset)
         conflict_cnt_r <= '0;
      else if (arb_en && ($countones(req) > 1) && (conflict_cnt_r != '1))
         conflict_cnt_r <= conflict_cnt_r + 1'b1;
   end

   assign conflict_cnt = conflict_cnt_r;
`endif

endmodule
